// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator with built-in test patterns. Horizontal and
//   vertical counters run from the pixel origin (first active pixel at
//   h_cnt=0, v_cnt=0) through the active region, front porch, sync and
//   back porch. All outputs are registered. The outputs after an edge
//   describe the counter state that was present before that edge.
//
// Ports
//   i_clk          pixel clock (only clock)
//   i_resetn       asynchronous active-low reset
//   i_en           run enable; low holds the generator idle at the origin
//   i_pattern      test-pattern select, sampled at the start of each frame
//   o_x, o_y       current column / line during active video, else 0
//   o_de           data enable, high on active pixels only
//   o_hsync        horizontal sync, asserted level HS_POL
//   o_vsync        vertical sync, asserted level VS_POL
//   o_frame_start  one-cycle pulse on pixel (0,0)
//   o_color        RGB888 {R,G,B}, black outside active video
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module video_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 12,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_frame_start,
   output logic [23:0] o_color
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Bars are H_ACTIVE/8 wide; guard against a zero divisor on tiny rasters.
   localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] BAR_WC = 12'(BAR_W);

   // Colour of each vertical bar, left to right.
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Counter state
   logic [11:0] h_q, h_d, v_q, v_d;
   logic [7:0]  frame_q, frame_d;
   logic [1:0]  pat_q, pat_d;

   // Registered outputs
   logic [11:0] x_q, x_d, y_q, y_d;
   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [23:0] color_q, color_d;

   // Decode of the current counter state
   logic        origin, active, hs_on, vs_on;
   logic [1:0]  pat_sel;
   logic [11:0] bar_idx;
   logic [23:0] pix_color;

   always_comb begin
      // NOTE: every variable gets a default before any branch so that no
      // path leaves it unassigned, which would otherwise infer a latch.
      origin  = (h_q == '0) && (v_q == '0);
      // A new pattern takes effect on the origin pixel itself.
      pat_sel = origin ? i_pattern : pat_q;
      active  = (h_q < H_ACT) && (v_q < V_ACT);
      hs_on   = (h_q >= H_SS) && (h_q < H_SE);
      vs_on   = (v_q >= V_SS) && (v_q < V_SE);
      bar_idx = h_q / BAR_WC;

      pix_color = 24'h000000;
      case (pat_sel)
         2'd0: pix_color = 24'hFFFFFF;
         2'd1: pix_color = (bar_idx < 12'd8) ? bar_color(bar_idx[2:0]) : 24'h000000;
         2'd2: pix_color = (h_q[5] ^ v_q[5]) ? 24'h000000 : 24'hFFFFFF;
         default: pix_color = {h_q[7:0], v_q[7:0], frame_q};
      endcase

      h_d     = '0;
      v_d     = '0;
      frame_d = '0;
      pat_d   = pat_q;
      de_d    = 1'b0;
      hs_d    = ~HS_POL;
      vs_d    = ~VS_POL;
      fs_d    = 1'b0;
      x_d     = '0;
      y_d     = '0;
      color_d = '0;

      if (i_en) begin
         pat_d   = pat_sel;
         de_d    = active;
         hs_d    = hs_on ? HS_POL : ~HS_POL;
         vs_d    = vs_on ? VS_POL : ~VS_POL;
         fs_d    = origin;
         x_d     = active ? h_q : '0;
         y_d     = active ? v_q : '0;
         color_d = active ? pix_color : '0;

         frame_d = frame_q;
         v_d     = v_q;
         h_d     = h_q + 12'd1;
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = v_q + 12'd1;
            if (v_q == V_LAST) begin
               v_d     = '0;
               frame_d = frame_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
         pat_q   <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         fs_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         pat_q   <= pat_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
      end
   end

   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_de          = de_q;
   assign o_hsync       = hs_q;
   assign o_vsync       = vs_q;
   assign o_frame_start = fs_q;
   assign o_color       = color_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Self-checking bench for video_timing_gen on a reduced raster
//   (130+4+8+12 = 154 clocks per line, 40+2+3+5 = 50 lines, 7700 clocks per
//   frame) with a non-multiple-of-8 width and HS_POL=1 / VS_POL=0.
//   A timeline model derives every output from the number of enabled
//   clocks since the origin; directed checks pin the model with literals.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_video_timing_gen;

   localparam int H_ACTIVE = 130;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 8;
   localparam int H_BP     = 12;
   localparam int H_TOTAL  = 154;
   localparam int V_ACTIVE = 40;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 3;
   localparam int V_BP     = 5;
   localparam int V_TOTAL  = 50;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam bit HS_POL   = 1'b1;
   localparam bit VS_POL   = 1'b0;

   // {de, hsync, vsync, frame_start, x, y, color}
   localparam logic [51:0] IDLE = {1'b0, ~HS_POL, ~VS_POL, 1'b0, 12'd0, 12'd0, 24'd0};

   logic        clk = 1'b0;
   logic        i_resetn, i_en;
   logic [1:0]  i_pattern;
   logic [11:0] o_x, o_y;
   logic        o_de, o_hsync, o_vsync, o_frame_start;
   logic [23:0] o_color;
   logic [51:0] dut_o;

   int checks = 0;
   int errors = 0;
   int k;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .i_clk(clk), .i_resetn(i_resetn), .i_en(i_en), .i_pattern(i_pattern),
      .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
      .o_frame_start(o_frame_start), .o_color(o_color)
   );

   assign dut_o = {o_de, o_hsync, o_vsync, o_frame_start, o_x, o_y, o_color};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   function automatic logic [23:0] pix(input int pat, input int x, input int y, input int f);
      int bar;
      case (pat)
         0: return 24'hFFFFFF;
         1: begin
            bar = x / (H_ACTIVE / 8);
            case (bar)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         2: return ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
         default: return {8'(x % 256), 8'(y % 256), 8'(f % 256)};
      endcase
   endfunction

   // t = number of enabled clocks since the origin.
   function automatic logic [51:0] model_out(input int t, input int pat);
      int  h, v, f;
      logic act, hs, vs;
      h   = t % H_TOTAL;
      v   = (t / H_TOTAL) % V_TOTAL;
      f   = (t / FRAME) % 256;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      return {act, hs, vs, (t % FRAME) == 0,
              act ? 12'(h) : 12'd0, act ? 12'(v) : 12'd0,
              act ? pix(pat, h, v, f) : 24'd0};
   endfunction

   // Per-cycle compare: model advanced at each edge, DUT sampled 1 ns later.
   initial begin
      int m_t, m_pat;
      logic [51:0] exp_o;
      m_t = 0;
      m_pat = 0;
      forever begin
         @(posedge clk);
         if (!i_resetn) begin
            m_t = 0;
            m_pat = 0;
            exp_o = IDLE;
         end else if (!i_en) begin
            m_t = 0;
            exp_o = IDLE;
         end else begin
            if (m_t % FRAME == 0) m_pat = int'(i_pattern);
            exp_o = model_out(m_t, m_pat);
            m_t++;
         end
         #1;
         check("cycle", 64'(dut_o), 64'(exp_o));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic goto(input int target);
      while (k < target) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   // Walks frame 0 sample by sample; sample i is the pixel at timeline i.
   task automatic measure_frame();
      int   de_line = 0, hs_first = -1, hs_cnt = 0;
      int   de_rises = 0, vs_first = -1, vs_cnt = 0, fs_at = -1;
      logic prev_de = 1'b0, de_end = 1'b1;
      for (int i = 0; i <= FRAME; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (i == 1) check("fs_one_cycle", 64'(o_frame_start), 64'd0);
         if (i < H_TOTAL) begin
            if (o_de) de_line++;
            if (o_hsync == HS_POL) begin
               if (hs_first < 0) hs_first = i;
               hs_cnt++;
            end
         end
         if (i == H_TOTAL - 1) de_end = o_de;
         if (i == H_TOTAL) check("line_period", 64'({de_end, o_de}), 64'b01);
         if (i < FRAME) begin
            if (o_de && !prev_de) de_rises++;
            if (o_vsync == VS_POL) begin
               if (vs_first < 0) vs_first = i;
               vs_cnt++;
            end
         end
         if (i > 0 && o_frame_start && fs_at < 0) fs_at = i;
         if (i == 4000) i_pattern = 2'd3;
         if (i == 5 + 30 * H_TOTAL) check("frame0_after_switch", 64'(o_color), 64'hFFFFFF);
         prev_de = o_de;
      end
      check("de_per_line",  64'(de_line),  64'd130);
      check("hs_offset",    64'(hs_first), 64'd134);
      check("hs_width",     64'(hs_cnt),   64'd8);
      check("de_lines",     64'(de_rises), 64'd40);
      check("vs_first",     64'(vs_first), 64'd6468);   // line 42 * 154
      check("vs_width",     64'(vs_cnt),   64'd462);    // 3 lines * 154
      check("frame_period", 64'(fs_at),    64'd7700);
      k = FRAME;
   endtask

   initial begin
      int base;
      i_resetn  = 1'b0;
      i_en      = 1'b0;
      i_pattern = 2'd0;
      k         = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_idle", 64'(dut_o), 64'(IDLE));

      i_en = 1'b1;
      @(negedge clk);
      i_resetn = 1'b1;
      @(posedge clk);
      #1;
      check("first_pixel", 64'({o_frame_start, o_de, o_x, o_y, o_color}),
            64'({1'b1, 1'b1, 12'd0, 12'd0, 24'hFFFFFF}));

      measure_frame();

      goto(FRAME + 1);
      i_pattern = 2'd1;
      goto(FRAME + 5 + 7 * H_TOTAL);
      check("p3_px_5_7", 64'({o_x, o_y, o_color}), 64'({12'd5, 12'd7, 24'h050701}));

      goto(2 * FRAME);
      check("frame2_start", 64'(o_frame_start), 64'd1);
      goto(2 * FRAME + 15);
      check("bar0_last", 64'(o_color), 64'hFFFFFF);
      goto(2 * FRAME + 16);
      check("bar1_first", 64'(o_color), 64'hFFFF00);
      goto(2 * FRAME + 80);
      check("bar5", 64'(o_color), 64'hFF0000);
      goto(2 * FRAME + 129);
      check("beyond_bars", 64'({o_de, o_color}), 64'({1'b1, 24'h000000}));
      goto(2 * FRAME + 200);
      i_pattern = 2'd2;

      goto(3 * FRAME + 31);
      check("chk_31_0", 64'(o_color), 64'hFFFFFF);
      goto(3 * FRAME + 32);
      check("chk_32_0", 64'(o_color), 64'h000000);
      goto(3 * FRAME + 32 + 32 * H_TOTAL);
      check("chk_32_32", 64'(o_color), 64'hFFFFFF);

      goto(3 * FRAME + 100 + 35 * H_TOTAL);
      check("pos_100_35", 64'({o_x, o_y}), 64'({12'd100, 12'd35}));
      i_en = 1'b0;
      goto(k + 1);
      check("disable_idle", 64'(dut_o), 64'(IDLE));
      i_pattern = 2'd3;
      goto(k + 4);
      i_en = 1'b1;
      goto(k + 1);
      check("restart", 64'({o_frame_start, o_de, o_x, o_y}), 64'({1'b1, 1'b1, 12'd0, 12'd0}));
      base = k;
      goto(base + 5 + 7 * H_TOTAL);
      check("restart_frame_cnt", 64'(o_color), 64'h050700);

      goto(k + 10);
      #2;
      i_resetn = 1'b0;
      #1;
      check("async_reset_idle", 64'(dut_o), 64'(IDLE));
      repeat (2) @(posedge clk);
      #1;
      i_pattern = 2'd0;
      i_resetn  = 1'b1;
      @(posedge clk);
      #1;
      check("reset_restart", 64'({o_frame_start, o_de, o_color}), 64'({1'b1, 1'b1, 24'hFFFFFF}));

      repeat (200) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
